// File: rtl/uart_tx_feeder.sv
// Word FIFO feeding the UART transmitter over TxData/TxReq/TxBusy. It enforces an
// idle gap between frames, drops unacknowledged requests and counts completed frames.
module uart_tx_feeder #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [DATA_WIDTH-1:0]   TxData,
   output logic                    TxReq,
   input  logic                    TxBusy,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [15:0]             frames_sent,
   output logic                    err_timeout,
   input  logic                    clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(ACK_TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic                    r_tx_req;
   logic [WW-1:0]           r_wait;
   logic [GW-1:0]           r_gap;
   logic [15:0]             r_frames;
   logic                    r_err;

   logic                    w_wr_ready;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_req_nxt;
   logic [WW-1:0]           w_wait_nxt;
   logic [GW-1:0]           w_gap_nxt;
   logic                    w_set_err;
   logic                    w_frame_done;

   // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
   assign w_wr_ready  = (r_count < CW'(DEPTH));
   assign w_push      = wr_valid && w_wr_ready;
   assign wr_ready    = w_wr_ready;
   assign fifo_count  = r_count;
   assign TxData      = r_tx_data;
   assign TxReq       = r_tx_req;
   assign frames_sent = r_frames;
   assign err_timeout = r_err;

   // FSM next-state and per-cycle control decode.
   always_comb begin
      w_state_nxt  = r_state;
      w_pop        = 1'b0;
      w_req_nxt    = r_tx_req;
      w_wait_nxt   = r_wait;
      w_gap_nxt    = r_gap;
      w_set_err    = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((r_count != {CW{1'b0}}) && !TxBusy) begin
               w_pop       = 1'b1;
               w_req_nxt   = 1'b1;
               w_wait_nxt  = {WW{1'b0}};
               w_state_nxt = ST_REQ;
            end else begin
               w_req_nxt   = 1'b0;
            end
         end
         ST_REQ: begin
            // An acknowledge in the timeout cycle takes priority over the timeout.
            if (TxBusy) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = ST_SEND;
            end else if (r_wait == WW'(ACK_TIMEOUT - 1)) begin
               w_req_nxt   = 1'b0;
               w_set_err   = 1'b1;
               w_gap_nxt   = {GW{1'b0}};
               w_state_nxt = ST_GAP;
            end else begin
               w_wait_nxt  = r_wait + WW'(1);
            end
         end
         ST_SEND: begin
            w_req_nxt = 1'b0;
            if (!TxBusy) begin
               w_frame_done = 1'b1;
               w_gap_nxt    = {GW{1'b0}};
               w_state_nxt  = ST_GAP;
            end else begin
               w_state_nxt  = ST_SEND;
            end
         end
         ST_GAP: begin
            w_req_nxt = 1'b0;
            if (r_gap == GW'(GAP_CYCLES - 1)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_nxt   = r_gap + GW'(1);
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // UART-facing outputs, FSM counters, frame counter and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_data <= {DATA_WIDTH{1'b0}};
         r_tx_req  <= 1'b0;
         r_wait    <= {WW{1'b0}};
         r_gap     <= {GW{1'b0}};
         r_frames  <= 16'd0;
         r_err     <= 1'b0;
      end else begin
         r_tx_req <= w_req_nxt;
         r_wait   <= w_wait_nxt;
         r_gap    <= w_gap_nxt;
         if (w_pop)        r_tx_data <= r_mem[r_rptr];
         if (w_frame_done) r_frames  <= r_frames + 16'd1;
         if (w_set_err) begin
            r_err <= 1'b1;
         end else if (clr_err) begin
            r_err <= 1'b0;
         end
      end
   end

endmodule
